// File: rtl/target_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : target_scheduler
// Purpose  : Per-frame, in-order sharing of the VGA write port among N draw
//            engines. Optional watchdog: define TARGET_SCHED_WATCHDOG_EN.
// Revision : 1.0
// ============================================================================
module target_scheduler #(
    parameter int N_TARGETS    = 3,
    parameter int FRAME_CYCLES = 833333,
    parameter int TIMEOUT      = 8192
) (
    input  logic                      CLOCK_50,
    input  logic                      resetn,
    input  logic                      enable,
    input  logic [N_TARGETS-1:0]      tgt_done,
    input  logic [N_TARGETS-1:0]      tgt_plot,
    input  logic [8*N_TARGETS-1:0]    tgt_x,
    input  logic [7*N_TARGETS-1:0]    tgt_y,
    input  logic [24*N_TARGETS-1:0]   tgt_colour,
    output logic [N_TARGETS-1:0]      tgt_active,
    output logic [N_TARGETS-1:0]      tgt_start,
    output logic [7:0]                vga_x,
    output logic [6:0]                vga_y,
    output logic [23:0]               vga_colour,
    output logic                      vga_plot,
    output logic                      frame_tick,
    output logic                      busy,
    output logic [7:0]                overrun,
    output logic [N_TARGETS-1:0]      timeout_err
);

    localparam int FC_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int SEL_W = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;
    localparam logic [FC_W-1:0]  FC_LOAD  = FC_W'(FRAME_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_TARGETS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_KICK      = 3'd1,
        S_WAIT_LOW  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_NEXT      = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [N_TARGETS-1:0]   drawn_q, drawn_d;
    logic [FC_W-1:0]        frame_cnt_q;
    logic                   pending_q, pending_d;
    logic [7:0]             overrun_q;
    logic [7:0]             vga_x_q;
    logic [6:0]             vga_y_q;
    logic [23:0]            vga_colour_q;
    logic                   vga_plot_q;

    logic [N_TARGETS-1:0]   sel_onehot;
    logic                   tick;
    logic                   consume;
    logic                   grant_st;
    logic                   waiting;
    logic                   timeout_hit;
    logic                   wd_expire;
    logic                   done_sel;
    logic                   drawn_sel;
    logic                   plot_sel;
    logic [7:0]             pix_x;
    logic [6:0]             pix_y;
    logic [23:0]            pix_colour;

    assign sel_onehot = N_TARGETS'(1) << sel_q;
    assign done_sel   = |(tgt_done & sel_onehot);
    assign drawn_sel  = |(drawn_q & sel_onehot);
    assign plot_sel   = |(tgt_plot & sel_onehot);
    assign tick       = (frame_cnt_q == '0);
    assign waiting    = (state_q == S_WAIT_LOW) || (state_q == S_WAIT_DONE);
    assign busy       = (state_q != S_IDLE);
    assign frame_tick = tick;

    // A tick landing in the same cycle IDLE consumes the flag is not late.
    assign pending_d  = (pending_q & ~consume) | tick;

    always_comb begin
        pix_x      = '0;
        pix_y      = '0;
        pix_colour = '0;
        for (int i = 0; i < N_TARGETS; i++) begin
            if (sel_q == SEL_W'(i)) begin
                pix_x      = tgt_x[8*i +: 8];
                pix_y      = tgt_y[7*i +: 7];
                pix_colour = tgt_colour[24*i +: 24];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        drawn_d     = drawn_q;
        consume     = 1'b0;
        grant_st    = 1'b0;
        timeout_hit = 1'b0;
        tgt_active  = '0;
        tgt_start   = '0;
        case (state_q)
            S_IDLE: begin
                sel_d = '0;
                if (pending_q && enable) begin
                    consume = 1'b1;
                    state_d = S_KICK;
                end
            end
            S_KICK: begin
                grant_st   = 1'b1;
                tgt_active = sel_onehot;
                if (drawn_sel) begin
                    tgt_start = sel_onehot;
                    state_d   = S_WAIT_LOW;
                end else begin
                    state_d   = S_WAIT_DONE;
                end
            end
            S_WAIT_LOW: begin
                grant_st   = 1'b1;
                tgt_active = sel_onehot;
                if (wd_expire) begin
                    timeout_hit = 1'b1;
                    state_d     = S_NEXT;
                end else if (!done_sel) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                grant_st   = 1'b1;
                tgt_active = sel_onehot;
                if (done_sel) begin
                    drawn_d = drawn_q | sel_onehot;
                    state_d = S_NEXT;
                end else if (wd_expire) begin
                    timeout_hit = 1'b1;
                    state_d     = S_NEXT;
                end
            end
            S_NEXT: begin
                if (sel_q == SEL_LAST) begin
                    sel_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    sel_d   = sel_q + SEL_W'(1);
                    state_d = S_KICK;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            sel_q        <= '0;
            drawn_q      <= '0;
            frame_cnt_q  <= FC_LOAD;
            pending_q    <= 1'b0;
            overrun_q    <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            drawn_q      <= drawn_d;
            frame_cnt_q  <= tick ? FC_LOAD : (frame_cnt_q - FC_W'(1));
            pending_q    <= pending_d;
            if (tick && ((pending_q && !consume) || busy) && (overrun_q != 8'hFF)) begin
                overrun_q <= overrun_q + 8'd1;
            end
            vga_x_q      <= pix_x;
            vga_y_q      <= pix_y;
            vga_colour_q <= pix_colour;
            vga_plot_q   <= plot_sel && grant_st;
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
    assign overrun    = overrun_q;

`ifdef TARGET_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0]        wd_cnt_q;
    logic [N_TARGETS-1:0]   timeout_err_q;

    // Fires on the cycle that would complete TIMEOUT waiting cycles.
    assign wd_expire = waiting && (wd_cnt_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            wd_cnt_q      <= '0;
            timeout_err_q <= '0;
        end else begin
            if (state_q == S_KICK) begin
                wd_cnt_q <= '0;
            end else if (waiting) begin
                wd_cnt_q <= wd_cnt_q + WD_W'(1);
            end
            if (timeout_hit) begin
                timeout_err_q <= timeout_err_q | sel_onehot;
            end
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0) | timeout_hit | waiting;
    assign wd_expire      = 1'b0;
    assign timeout_err    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_target_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_target_scheduler
// Purpose  : Directed bench for target_scheduler with behavioural draw engines.
// Revision : 1.0
// ============================================================================
module tb_target_scheduler;

    localparam int N  = 3;
    localparam int FC = 200;
    localparam int TO = 300;

    logic              clk = 1'b0;
    logic              resetn;
    logic              enable;
    logic [N-1:0]      tgt_done;
    logic [N-1:0]      tgt_plot;
    logic [8*N-1:0]    tgt_x;
    logic [7*N-1:0]    tgt_y;
    logic [24*N-1:0]   tgt_colour;
    logic [N-1:0]      tgt_active;
    logic [N-1:0]      tgt_start;
    logic [7:0]        vga_x;
    logic [6:0]        vga_y;
    logic [23:0]       vga_colour;
    logic              vga_plot;
    logic              frame_tick;
    logic              busy;
    logic [7:0]        overrun;
    logic [N-1:0]      timeout_err;

    int checks   = 0;
    int failures = 0;

    int           len;
    logic [N-1:0] hang;
    logic         force_plot1;
    logic [N-1:0] eng_done;
    int           eng_cnt [N];

    always #5 clk = ~clk;

    target_scheduler #(
        .N_TARGETS    (N),
        .FRAME_CYCLES (FC),
        .TIMEOUT      (TO)
    ) dut (
        .CLOCK_50    (clk),
        .resetn      (resetn),
        .enable      (enable),
        .tgt_done    (tgt_done),
        .tgt_plot    (tgt_plot),
        .tgt_x       (tgt_x),
        .tgt_y       (tgt_y),
        .tgt_colour  (tgt_colour),
        .tgt_active  (tgt_active),
        .tgt_start   (tgt_start),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .frame_tick  (frame_tick),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    // Engine: start clears done and reloads; drawing advances only while granted.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!resetn) begin
                eng_done[i] <= 1'b0;
                eng_cnt[i]  <= len;
            end else if (tgt_start[i]) begin
                eng_done[i] <= 1'b0;
                eng_cnt[i]  <= len;
            end else if (tgt_active[i] && !eng_done[i] && !hang[i]) begin
                if (eng_cnt[i] == 0) eng_done[i] <= 1'b1;
                else                 eng_cnt[i]  <= eng_cnt[i] - 1;
            end
        end
    end

    always_comb begin
        tgt_done   = '0;
        tgt_plot   = '0;
        tgt_x      = '0;
        tgt_y      = '0;
        tgt_colour = '0;
        for (int i = 0; i < N; i++) begin
            tgt_done[i]             = eng_done[i];
            tgt_plot[i]             = tgt_active[i] && !eng_done[i];
            tgt_x[8*i +: 8]         = {1'b1, 2'(i), 5'(eng_cnt[i])};
            tgt_y[7*i +: 7]         = 7'(eng_cnt[i]);
            tgt_colour[24*i +: 24]  = {8'(i), 16'(eng_cnt[i])};
        end
        if (force_plot1) begin
            tgt_plot[1]  = 1'b1;
            tgt_x[15:8]  = 8'd5;
        end
    end

    int o_order[$];
    int o_gaps[$];
    int o_starts [N];
    int o_kick_start [N];
    int o_misalign, o_onehot_err, o_drop_err, o_busy_wait;
    bit o_expired;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int order_code();
        int c = 0;
        foreach (o_order[k]) c = c * 10 + o_order[k] + 1;
        return c;
    endfunction

    function automatic int gap_code();
        int c = 0;
        foreach (o_gaps[k]) c = c * 10 + o_gaps[k];
        return c;
    endfunction

    // Records grant order, start pulses and hand-off timing over one frame.
    task automatic observe_frame(input int budget);
        logic [N-1:0] p_act, p_done, armed, act;
        int low_run, n;
        o_order.delete();
        o_gaps.delete();
        for (int i = 0; i < N; i++) begin
            o_starts[i] = 0;
            o_kick_start[i] = 0;
        end
        o_misalign = 0; o_onehot_err = 0; o_drop_err = 0; o_expired = 0;
        p_act = '0; p_done = '0; armed = '0; low_run = 0;
        n = 0;
        while (busy !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        o_busy_wait = n;
        if (busy !== 1'b1) begin
            o_expired = 1;
            return;
        end
        n = 0;
        while (n < budget) begin
            act = tgt_active;
            if ((act & (act - 1'b1)) != '0) o_onehot_err++;
            for (int j = 0; j < N; j++) begin
                if (p_act[j] && (act[j] !== !(armed[j] && p_done[j]))) o_drop_err++;
                if (act[j] && !p_act[j]) begin
                    if (o_order.size() > 0) o_gaps.push_back(low_run);
                    o_order.push_back(j);
                    o_kick_start[j] = int'(tgt_start[j]);
                    armed[j] = 1'b0;
                end
                if (tgt_start[j]) begin
                    o_starts[j]++;
                    if (!(act[j] && !p_act[j])) o_misalign++;
                end
                if (!act[j])           armed[j] = 1'b0;
                else if (!tgt_done[j]) armed[j] = 1'b1;
            end
            low_run = (act == '0) ? low_run + 1 : 0;
            p_act  = act;
            p_done = tgt_done;
            if (busy !== 1'b1) break;
            @(negedge clk);
            n++;
        end
        if (n >= budget) o_expired = 1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; enable = 1'b1; len = 20; hang = '0; force_plot1 = 1'b0;
        step(3);
        checks++;
        if ({tgt_active, tgt_start, vga_x, vga_y, vga_colour, vga_plot, frame_tick, busy, timeout_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {tgt_active, tgt_start, vga_x, vga_y, vga_colour, vga_plot, frame_tick, busy, timeout_err});
        end
        checks++;
        if (overrun !== 8'd0) begin failures++; $display("FAIL reset_overrun got=%0d exp=0", overrun); end
    endtask

    task automatic test_first_frame();
        resetn = 1'b1;
        step(FC - 2);
        checks++;
        if (frame_tick !== 1'b0) begin failures++; $display("FAIL tick_early got=%b exp=0", frame_tick); end
        step(1);
        checks++;
        if (frame_tick !== 1'b1) begin failures++; $display("FAIL tick_at_zero got=%b exp=1", frame_tick); end
        step(1);
        checks++;
        if ({busy, frame_tick, tgt_active} !== '0) begin
            failures++; $display("FAIL pending_idle got=%b exp=0", {busy, frame_tick, tgt_active});
        end
        observe_frame(2000);
        checks++;
        if (o_expired || o_busy_wait != 1) begin
            failures++; $display("FAIL f1_grant_latency got=%0d exp=1 expired=%0d", o_busy_wait, o_expired);
        end
        checks++;
        if (order_code() != 123) begin failures++; $display("FAIL f1_order got=%0d exp=123", order_code()); end
        checks++;
        if (o_starts[0] + o_starts[1] + o_starts[2] != 0) begin
            failures++; $display("FAIL f1_no_start got=%0d exp=0", o_starts[0] + o_starts[1] + o_starts[2]);
        end
        checks++;
        if (gap_code() != 11) begin failures++; $display("FAIL f1_gaps got=%0d exp=11", gap_code()); end
        checks++;
        if (o_onehot_err + o_drop_err != 0) begin
            failures++; $display("FAIL f1_handoff got=%0d/%0d exp=0/0", o_onehot_err, o_drop_err);
        end
    endtask

    task automatic test_second_frame();
        observe_frame(3 * FC);
        checks++;
        if (o_expired || order_code() != 123) begin
            failures++; $display("FAIL f2_order got=%0d exp=123 expired=%0d", order_code(), o_expired);
        end
        checks++;
        if (o_starts[0] * 100 + o_starts[1] * 10 + o_starts[2] != 111) begin
            failures++; $display("FAIL f2_starts got=%0d%0d%0d exp=111", o_starts[0], o_starts[1], o_starts[2]);
        end
        checks++;
        if (o_kick_start[0] * 100 + o_kick_start[1] * 10 + o_kick_start[2] != 111 || o_misalign != 0) begin
            failures++; $display("FAIL f2_start_at_kick got=%0d%0d%0d misalign=%0d exp=111/0",
                                 o_kick_start[0], o_kick_start[1], o_kick_start[2], o_misalign);
        end
        checks++;
        if (o_drop_err != 0 || o_onehot_err != 0) begin
            failures++; $display("FAIL f2_hold_drop got=%0d/%0d exp=0/0", o_drop_err, o_onehot_err);
        end
    endtask

    task automatic test_isolation();
        int n = 0, plot_seen = 0, bad = 0, leak = 0;
        logic [N-1:0] p_act = '0;
        logic         p_plot0 = 1'b0;
        logic [7:0]   p_x0 = '0;
        force_plot1 = 1'b1;
        while (busy !== 1'b1 && n < 3 * FC) begin @(negedge clk); n++; end
        n = 0;
        while (n < 3 * FC) begin
            if (p_act == 3'b001) begin
                if (vga_plot === 1'b1) plot_seen++;
                if (vga_plot !== p_plot0 || vga_x !== p_x0 || vga_x === 8'd5) bad++;
            end
            if (p_act == '0 && vga_plot !== 1'b0) leak++;
            p_act = tgt_active; p_plot0 = tgt_plot[0]; p_x0 = tgt_x[7:0];
            if (busy !== 1'b1) break;
            @(negedge clk);
            n++;
        end
        force_plot1 = 1'b0;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL iso_follow_eng0 got=%0d exp=0", bad); end
        checks++;
        if (leak != 0) begin failures++; $display("FAIL iso_no_grant_plot got=%0d exp=0", leak); end
        checks++;
        if (plot_seen != len + 1) begin failures++; $display("FAIL iso_plot_count got=%0d exp=%0d", plot_seen, len + 1); end
    endtask

    task automatic test_enable_low();
        int n = 0, busy_seen = 0;
        while (busy !== 1'b1 && n < 3 * FC) begin @(negedge clk); n++; end
        enable = 1'b0;
        observe_frame(3 * FC);
        checks++;
        if (o_expired || order_code() != 123) begin
            failures++; $display("FAIL en_low_completes got=%0d exp=123 expired=%0d", order_code(), o_expired);
        end
        for (int k = 0; k < 250; k++) begin
            step(1);
            if (busy === 1'b1) busy_seen++;
        end
        checks++;
        if (busy_seen != 0) begin failures++; $display("FAIL en_low_holds got=%0d exp=0", busy_seen); end
        checks++;
        if (overrun !== 8'd0) begin failures++; $display("FAIL en_low_overrun got=%0d exp=0", overrun); end
        enable = 1'b1;
        step(1);
        checks++;
        if (busy !== 1'b1 || tgt_active !== 3'b001) begin
            failures++; $display("FAIL en_high_pending got=%b/%b exp=1/001", busy, tgt_active);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        while (tgt_active !== 3'b010 && n < 3 * FC) begin @(negedge clk); n++; end
        step(5);
        checks++;
        if (tgt_active !== 3'b010 || vga_plot !== 1'b1) begin
            failures++; $display("FAIL mid_setup got=%b/%b exp=010/1", tgt_active, vga_plot);
        end
        resetn = 1'b0;
        step(1);
        checks++;
        if ({tgt_active, tgt_start, vga_x, vga_y, vga_colour, vga_plot, frame_tick, busy, overrun, timeout_err} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%h exp=0",
                     {tgt_active, tgt_start, vga_x, vga_y, vga_colour, vga_plot, frame_tick, busy, overrun, timeout_err});
        end
        resetn = 1'b1;
        observe_frame(3 * FC);
        checks++;
        if (o_expired || order_code() != 123 || o_starts[0] + o_starts[1] + o_starts[2] != 0) begin
            failures++; $display("FAIL mid_after_reset got=%0d starts=%0d exp=123/0",
                                 order_code(), o_starts[0] + o_starts[1] + o_starts[2]);
        end
    endtask

    task automatic test_overrun();
        len = 300;
        resetn = 1'b0;
        step(2);
        resetn = 1'b1;
        step(2 * FC - 1);
        checks++;
        if (overrun !== 8'd0) begin failures++; $display("FAIL ovr_first_tick got=%0d exp=0", overrun); end
        step(1);
        checks++;
        if (overrun !== 8'd1) begin failures++; $display("FAIL ovr_second_tick got=%0d exp=1", overrun); end
        step(FC);
        checks++;
        if (overrun !== 8'd2) begin failures++; $display("FAIL ovr_third_tick got=%0d exp=2", overrun); end
        step(60000);
        checks++;
        if (overrun !== 8'd255) begin failures++; $display("FAIL ovr_saturate got=%0d exp=255", overrun); end
        step(5 * FC);
        checks++;
        if (overrun !== 8'd255) begin failures++; $display("FAIL ovr_hold got=%0d exp=255", overrun); end
        len = 20;
    endtask

`ifdef TARGET_SCHED_WATCHDOG_EN
    task automatic test_watchdog();
        int n = 0;
        hang = 3'b100;
        resetn = 1'b0;
        step(2);
        resetn = 1'b1;
        while (tgt_active !== 3'b100 && n < 10 * FC) begin @(negedge clk); n++; end
        n = 0;
        while (timeout_err === '0 && n < TO + 50) begin step(1); n++; end
        checks++;
        if (n != TO + 1 || timeout_err !== 3'b100) begin
            failures++; $display("FAIL wd_fire got=%0d/%b exp=%0d/100", n, timeout_err, TO + 1);
        end
        checks++;
        if (tgt_active !== 3'b000) begin failures++; $display("FAIL wd_release got=%b exp=000", tgt_active); end
        step(1);
        observe_frame(10 * FC);
        checks++;
        if (o_expired || order_code() != 123) begin
            failures++; $display("FAIL wd_next_frame got=%0d exp=123", order_code());
        end
        checks++;
        if (o_starts[0] * 100 + o_starts[1] * 10 + o_starts[2] != 110 || timeout_err !== 3'b100) begin
            failures++; $display("FAIL wd_drawn got=%0d%0d%0d/%b exp=110/100",
                                 o_starts[0], o_starts[1], o_starts[2], timeout_err);
        end
        hang = '0;
    endtask
`else
    task automatic test_watchdog();
        checks++;
        if (timeout_err !== '0) begin failures++; $display("FAIL wd_tied got=%b exp=000", timeout_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_first_frame();
        test_second_frame();
        test_isolation();
        test_enable_low();
        test_reset_mid_frame();
        test_overrun();
        test_watchdog();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
